execute_lsu: RTL

EXECUTE_LSU -- requirements
Module: execute_lsu

---
 rtl/execute_lsu_pkg.sv | 63 ++++++
 rtl/execute_lsu_if.sv | 22 ++
 rtl/execute_regfile.sv | 44 ++++
 rtl/execute_lsu.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/execute_lsu_pkg.sv
// Shared types for the execute/load-store stage: decoded instruction,
// epoch colours, memory control and execute state encodings.
package execute_lsu_pkg;

  // Widths of the decodedInstT fields; the execute_lsu XLEN/NREGS
  // parameters must stay consistent with these.
  localparam int unsigned PKG_XLEN  = 32;
  localparam int unsigned PKG_REG_W = 5;

  typedef enum logic [1:0] {
    EPOCH_RED     = 2'd0,
    EPOCH_GREEN   = 2'd1,
    EPOCH_INVALID = 2'd3
  } EpochT;

  typedef enum logic [1:0] {
    MEM_NONE  = 2'd0,
    MEM_READ  = 2'd1,
    MEM_WRITE = 2'd2
  } MemControlT;

  typedef enum logic [1:0] {
    EX_RUNNING   = 2'd0,
    EX_LOAD_WAIT = 2'd1,
    EX_ERROR     = 2'd2
  } ExecuteStateT;

  // Any encoding not listed here is treated as undefined.
  typedef enum logic [3:0] {
    INST_ADD   = 4'd0,
    INST_ADDI  = 4'd1,
    INST_AUIPC = 4'd2,
    INST_LUI   = 4'd3,
    INST_BLT   = 4'd4,
    INST_JAL   = 4'd5,
    INST_JALR  = 4'd6,
    INST_LW    = 4'd7,
    INST_SW    = 4'd8,
    INST_UNDEF = 4'hF
  } InstT;

  typedef struct packed {
    InstT                inst;
    logic [PKG_XLEN-1:0] imm;   // already sign-extended / shifted by decode
  } decT;

  typedef struct packed {
    logic [PKG_REG_W-1:0] rs1;
    logic [PKG_REG_W-1:0] rs2;
    logic [PKG_REG_W-1:0] rd;
  } fieldsT;

  typedef struct packed {
    logic [PKG_XLEN-1:0] pc;
    decT                 dec;
    fieldsT              fields;
  } decodedInstT;

  function automatic EpochT nextEpochColour(input EpochT e);
    return (e == EPOCH_RED) ? EPOCH_GREEN : EPOCH_RED;
  endfunction

endpackage

// File: rtl/execute_lsu_if.sv
// Data-memory bus between the execute stage (master) and memory (slave).
interface execute_lsu_if #(
  parameter int unsigned XLEN = 32
);
  import execute_lsu_pkg::*;

  MemControlT      dmem_control;
  logic [XLEN-1:0] dmem_addr;
  logic [XLEN-1:0] dmem_writedata;
  logic [XLEN-1:0] dmem_readdata;
  logic            dmem_readdata_valid;

  modport master (
    output dmem_control, dmem_addr, dmem_writedata,
    input  dmem_readdata, dmem_readdata_valid
  );

  modport slave (
    input  dmem_control, dmem_addr, dmem_writedata,
    output dmem_readdata, dmem_readdata_valid
  );
endinterface

// File: rtl/execute_regfile.sv
// Architectural register file: NREGS x XLEN, two combinational read
// ports, one synchronous write port, x0 hardwired to zero.
module execute_regfile #(
  parameter  int unsigned XLEN  = 32,
  parameter  int unsigned NREGS = 32,
  localparam int unsigned RW    = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [RW-1:0]   ra1,
  output logic [XLEN-1:0] rd1,
  input  logic [RW-1:0]   ra2,
  output logic [XLEN-1:0] rd2,
  input  logic            we,
  input  logic [RW-1:0]   wa,
  input  logic [XLEN-1:0] wd
);

  logic [XLEN-1:0] regs_q [NREGS];
  logic [XLEN-1:0] regs_d [NREGS];

  // Next register contents: apply the single write, never to x0
  always_comb begin
    regs_d = regs_q;
    if (we && (wa != '0)) begin
      regs_d[wa] = wd;
    end
  end

  // Register storage with synchronous clear
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  assign rd1 = (ra1 == '0) ? '0 : regs_q[ra1];
  assign rd2 = (ra2 == '0) ? '0 : regs_q[ra2];

endmodule

// File: rtl/execute_lsu.sv
// Execute stage with integrated load/store unit: ALU ops, BLT/JAL/JALR
// redirects with epoch colouring, single-cycle stores and blocking loads
// with a timeout into a sticky error state.
// Optional macro EXECUTE_MISALIGN_TRAP_EN: misaligned LW/SW trap to
// EX_ERROR instead of being silently word-aligned.
module execute_lsu
  import execute_lsu_pkg::*;
#(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned NREGS       = 32,
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic            clk,
  input  logic            rst,
  input  decodedInstT     d,
  input  logic            d_valid,
  output logic            d_ready,
  input  EpochT           d_epoch,
  output logic [XLEN-1:0] jumpPC,
  output EpochT           jumpEpoch,
  output ExecuteStateT    executeState,
  execute_lsu_if.master   dmem
);

  localparam int unsigned     RW          = $clog2(NREGS);
  localparam int unsigned     CNT_W       = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(MEM_TIMEOUT);

  ExecuteStateT     state_q, state_d;
  EpochT            epoch_q, epoch_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [RW-1:0]    load_rd_q, load_rd_d;

  logic [XLEN-1:0]  pc, imm, rs1_val, rs2_val, eff_addr, word_addr;
  logic [RW-1:0]    rs1_idx, rs2_idx, rd_idx;
  logic             live, addr_ok;
  logic             rf_we;
  logic [RW-1:0]    rf_wa;
  logic [XLEN-1:0]  rf_wd;

  assign pc        = XLEN'(d.pc);
  assign imm       = XLEN'(d.dec.imm);
  assign rs1_idx   = RW'(d.fields.rs1);
  assign rs2_idx   = RW'(d.fields.rs2);
  assign rd_idx    = RW'(d.fields.rd);
  assign eff_addr  = rs1_val + imm;
  assign word_addr = eff_addr & ~XLEN'(3);

`ifdef EXECUTE_MISALIGN_TRAP_EN
  assign addr_ok = (eff_addr[1:0] == 2'b00);
`else
  assign addr_ok = 1'b1;
`endif

  // d_ready is forced high while rst is asserted so the reset-time
  // outputs do not depend on whatever state the flops held before.
  assign d_ready      = rst || (state_q == EX_RUNNING);
  assign live         = !rst && d_valid && (state_q == EX_RUNNING) && (d_epoch == epoch_q);
  assign executeState = state_q;

  execute_regfile #(
    .XLEN  (XLEN),
    .NREGS (NREGS)
  ) u_regfile (
    .clk (clk),
    .rst (rst),
    .ra1 (rs1_idx),
    .rd1 (rs1_val),
    .ra2 (rs2_idx),
    .rd2 (rs2_val),
    .we  (rf_we),
    .wa  (rf_wa),
    .wd  (rf_wd)
  );

  // Next-state, register write, redirect and memory request decode
  always_comb begin
    state_d               = state_q;
    epoch_d               = epoch_q;
    wait_cnt_d            = wait_cnt_q;
    load_rd_d             = load_rd_q;
    rf_we                 = 1'b0;
    rf_wa                 = rd_idx;
    rf_wd                 = '0;
    jumpPC                = '0;
    jumpEpoch             = EPOCH_INVALID;
    dmem.dmem_control     = MEM_NONE;
    dmem.dmem_addr        = '0;
    dmem.dmem_writedata   = '0;

    case (state_q)
      EX_RUNNING: begin
        if (live) begin
          case (d.dec.inst)
            INST_ADD:   begin rf_we = 1'b1; rf_wd = rs1_val + rs2_val; end
            INST_ADDI:  begin rf_we = 1'b1; rf_wd = rs1_val + imm; end
            INST_AUIPC: begin rf_we = 1'b1; rf_wd = pc + imm; end
            INST_LUI:   begin rf_we = 1'b1; rf_wd = imm; end
            INST_BLT: begin
              if ($signed(rs1_val) < $signed(rs2_val)) begin
                jumpPC    = pc + imm;
                jumpEpoch = nextEpochColour(epoch_q);
              end
            end
            INST_JAL: begin
              rf_we     = 1'b1;
              rf_wd     = pc + XLEN'(4);
              jumpPC    = pc + imm;
              jumpEpoch = nextEpochColour(epoch_q);
            end
            INST_JALR: begin
              rf_we     = 1'b1;
              rf_wd     = pc + XLEN'(4);
              jumpPC    = eff_addr & ~XLEN'(1);
              jumpEpoch = nextEpochColour(epoch_q);
            end
            INST_SW: begin
              if (!addr_ok) begin
                state_d = EX_ERROR;
              end else begin
                dmem.dmem_control   = MEM_WRITE;
                dmem.dmem_addr      = word_addr;
                dmem.dmem_writedata = rs2_val;
              end
            end
            INST_LW: begin
              if (!addr_ok) begin
                state_d = EX_ERROR;
              end else begin
                dmem.dmem_control = MEM_READ;
                dmem.dmem_addr    = word_addr;
                state_d           = EX_LOAD_WAIT;
                load_rd_d         = rd_idx;
                wait_cnt_d        = '0;
              end
            end
            default: state_d = EX_ERROR;
          endcase
          if (jumpEpoch != EPOCH_INVALID) begin
            epoch_d = jumpEpoch;
          end
        end
      end
      EX_LOAD_WAIT: begin
        if (dmem.dmem_readdata_valid) begin
          rf_we      = 1'b1;
          rf_wa      = load_rd_q;
          rf_wd      = dmem.dmem_readdata;
          state_d    = EX_RUNNING;
          wait_cnt_d = '0;
        end else begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
          if (wait_cnt_d == TIMEOUT_CNT) begin
            state_d = EX_ERROR;
          end
        end
      end
      default: ;
    endcase
  end

  // State, epoch, load-wait counter and pending load destination
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= EX_RUNNING;
      epoch_q    <= EPOCH_RED;
      wait_cnt_q <= '0;
      load_rd_q  <= '0;
    end else begin
      state_q    <= state_d;
      epoch_q    <= epoch_d;
      wait_cnt_q <= wait_cnt_d;
      load_rd_q  <= load_rd_d;
    end
  end

endmodule
